// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - host byte-stream loader and sequencer for the PAT instruction buffer write port
//
// Packs host bytes (little-endian) into W = I_BUFFER_SIZE*I_WIDTH bit words and writes them to
// consecutive instruction addresses, holding the PAT core in reset until a load completes.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   host_start          one-cycle load request, sampled only while idle
//   host_base_adr       first write address (captured on start)
//   host_count          number of words to load, 0..2^I_ADR_WIDTH (captured on start)
//   host_valid/ready    byte handshake, host_data carries the byte
//   imem_write_adr      write address (holds last value outside a write)
//   imem_write          one-cycle write strobe
//   imem_in             packed write word (holds last value outside a write)
//   core_hold           hold/reset request to the PAT core
//   busy, done          not idle / one-cycle completion pulse
//   error               sticky checksum mismatch
//
// Optional feature macro: LOADER_CHECKSUM_EN - a trailing byte must equal the XOR of all payload
// bytes; a mismatch sets error and keeps core_hold asserted. Undefined: error is tied 0.
module imem_loader #(
   parameter int I_WIDTH       = 23,
   parameter int I_BUFFER_SIZE = 2,
   parameter int I_ADR_WIDTH   = 10
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             host_start,
   input  logic [I_ADR_WIDTH-1:0]           host_base_adr,
   input  logic [I_ADR_WIDTH:0]             host_count,
   input  logic                             host_valid,
   input  logic [7:0]                       host_data,
   output logic                             host_ready,
   output logic [I_ADR_WIDTH-1:0]           imem_write_adr,
   output logic                             imem_write,
   output logic [I_BUFFER_SIZE*I_WIDTH-1:0] imem_in,
   output logic                             core_hold,
   output logic                             busy,
   output logic                             done,
   output logic                             error
);

   localparam int W      = I_BUFFER_SIZE * I_WIDTH;
   localparam int NBYTES = (W + 7) / 8;
   localparam int LOW_W  = 8 * (NBYTES - 1);   // bits held by all bytes but the last
   localparam int TOP_W  = W - LOW_W;          // bits of the last byte that survive
   localparam int IDX_W  = $clog2(NBYTES);

   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [I_ADR_WIDTH-1:0]   adr_q, adr_d;
   logic [I_ADR_WIDTH:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [LOW_W-1:0]         low_q, low_d;
   logic [I_ADR_WIDTH-1:0]   wadr_q, wadr_d;
   logic [W-1:0]             wdat_q, wdat_d;
   logic                     hold_q, hold_d;
`ifdef LOADER_CHECKSUM_EN
   logic                     err_q, err_d;
   logic [7:0]               sum_q, sum_d;
`endif

   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      low_d      = low_q;
      wadr_d     = wadr_q;
      wdat_d     = wdat_q;
      hold_d     = hold_q;
      host_ready = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_d      = err_q;
      sum_d      = sum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (host_start) begin
               adr_d  = host_base_adr;
               cnt_d  = host_count;
               idx_d  = '0;
               hold_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               err_d  = 1'b0;
               sum_d  = 8'h00;
               // an empty load still consumes (and verifies) the trailing checksum byte
               state_d = (host_count == '0) ? S_CHECK : S_RECV;
`else
               state_d = (host_count == '0) ? S_DONE : S_RECV;
`endif
            end
         end
         S_RECV: begin
            host_ready = 1'b1;
            if (host_valid) begin
`ifdef LOADER_CHECKSUM_EN
               sum_d = sum_q ^ host_data;
`endif
               if (idx_q == IDX_W'(NBYTES - 1)) begin
                  // final byte goes straight into the output word; its bits above W-1 are dropped
                  wdat_d  = {host_data[TOP_W-1:0], low_q};
                  wadr_d  = adr_q;
                  state_d = S_WRITE;
               end else begin
                  low_d[8*idx_q +: 8] = host_data;
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            adr_d = adr_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
            idx_d = '0;
            if (cnt_q == (I_ADR_WIDTH+1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_RECV;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            host_ready = 1'b1;
            if (host_valid) begin
               if (host_data != sum_q) err_d = 1'b1;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            // release the core on the way back to idle unless the image failed its checksum
`ifdef LOADER_CHECKSUM_EN
            hold_d = err_q;
`else
            hold_d = 1'b0;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         low_q   <= '0;
         wadr_q  <= '0;
         wdat_q  <= '0;
         hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         err_q   <= 1'b0;
         sum_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         low_q   <= low_d;
         wadr_q  <= wadr_d;
         wdat_q  <= wdat_d;
         hold_q  <= hold_d;
`ifdef LOADER_CHECKSUM_EN
         err_q   <= err_d;
         sum_q   <= sum_d;
`endif
      end
   end

   assign imem_write     = (state_q == S_WRITE);
   assign imem_write_adr = wadr_q;
   assign imem_in        = wdat_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign core_hold      = hold_q;
`ifdef LOADER_CHECKSUM_EN
   assign error          = err_q;
`else
   assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a word-level model
module tb_imem_loader;

   localparam int AW = 10;
   localparam int W  = 46;
   localparam int NB = 6;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          host_start = 1'b0;
   logic [AW-1:0] host_base_adr = '0;
   logic [AW:0]   host_count = '0;
   logic          host_valid = 1'b0;
   logic [7:0]    host_data = 8'h00;
   logic          host_ready;
   logic [AW-1:0] imem_write_adr;
   logic          imem_write;
   logic [W-1:0]  imem_in;
   logic          core_hold;
   logic          busy;
   logic          done;
   logic          error;

   imem_loader dut (
      .clk(clk), .reset(reset), .host_start(host_start), .host_base_adr(host_base_adr),
      .host_count(host_count), .host_valid(host_valid), .host_data(host_data),
      .host_ready(host_ready), .imem_write_adr(imem_write_adr), .imem_write(imem_write),
      .imem_in(imem_in), .core_hold(core_hold), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // model state: expected writes (driver pushes, comparer consumes by pointer)
   logic [AW-1:0] exp_adr[$];
   logic [W-1:0]  exp_dat[$];
   logic [7:0]    stim[$];
   int            load_id = 0;

   // observations kept by the comparer
   logic [AW-1:0] log_adr[$];
   logic [W-1:0]  log_dat[$];
   int  rd_ptr = 0;
   int  done_seen = 0;
   int  post_seen = 0;
   logic post_hold = 1'b0;
   logic post_busy = 1'b0;
   logic prev_done = 1'b0;
   int  last_wr = 0;
   int  wr_load = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         rd_ptr = exp_adr.size();          // reset abandons every outstanding word
         if (imem_write) chk("write_in_reset", imem_write, 1'b0);
      end else if (imem_write) begin
         if (rd_ptr >= exp_adr.size()) begin
            chk("unexpected_write", imem_write, 1'b0);
         end else begin
            chk("write_adr", imem_write_adr, exp_adr[rd_ptr]);
            chk("write_dat", imem_in, exp_dat[rd_ptr]);
            rd_ptr++;
         end
         if (wr_load == load_id) chk("write_spacing", (cyc - last_wr) >= NB + 1, 1'b1);
         last_wr = cyc;
         wr_load = load_id;
         log_adr.push_back(imem_write_adr);
         log_dat.push_back(imem_in);
      end
      if (prev_done) begin
         post_hold = core_hold;
         post_busy = busy;
         post_seen++;
      end
      prev_done = done;
      if (done) done_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] cnt);
      load_id++;
      host_start = 1'b1;
      host_base_adr = base;
      host_count = cnt;
      tick();
      host_start = 1'b0;
      host_base_adr = AW'($urandom);
      host_count = (AW+1)'($urandom);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rnd, input bit glitch);
      bit acc;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
         host_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         host_data = host_valid ? b : 8'($urandom);
         if (glitch && $urandom_range(0, 3) == 0) begin
            host_start = 1'b1;
            host_base_adr = AW'($urandom);
            host_count = (AW+1)'($urandom_range(1, 9));
         end
         @(negedge clk);
         acc = host_valid && host_ready;
         tick();
         host_start = 1'b0;
      end
      host_valid = 1'b0;
      if (!acc) chk("byte_accept_timeout", acc, 1'b1);
   endtask

   task automatic run_load(input logic [AW-1:0] base, input int cnt, input bit rnd,
                           input bit glitch, input logic [7:0] tweak);
      logic [47:0] word;
      logic [7:0]  bytes [NB];
      logic [7:0]  sum;
      logic        exp_err;
      int d0, p0;
      sum = 8'h00;
      d0 = done_seen;
      p0 = post_seen;
      start_load(base, (AW+1)'(cnt));
      @(negedge clk);
      chk("busy_after_start", busy, 1'b1);
      chk("hold_during_load", core_hold, 1'b1);
      tick();
      for (int w = 0; w < cnt; w++) begin
         word = '0;
         for (int k = 0; k < NB; k++) begin
            bytes[k] = (stim.size() > 0) ? stim.pop_front() : 8'($urandom);
            word = word | (48'(bytes[k]) << (8 * k));
            sum = sum ^ bytes[k];
         end
         exp_adr.push_back(AW'(int'(base) + w));
         exp_dat.push_back(word[W-1:0]);
         for (int k = 0; k < NB; k++) send_byte(bytes[k], rnd, glitch);
      end
      exp_err = CK && (tweak != 8'h00);
      if (CK) send_byte(sum ^ tweak, rnd, 1'b0);
      for (int t = 0; t < 50 && done_seen == d0; t++) tick();
      repeat (3) tick();
      chk("done_pulses", done_seen - d0, 1);
      chk("post_done_sampled", post_seen - p0, 1);
      chk("hold_after_done", post_hold, exp_err);
      chk("busy_after_done", post_busy, 1'b0);
      chk("error_flag", error, exp_err);
      chk("writes_outstanding", exp_adr.size() - rd_ptr, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_core_hold", core_hold, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_host_ready", host_ready, 1'b0);
      chk("rst_imem_write", imem_write, 1'b0);
      chk("rst_imem_in", imem_in, '0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      n0 = log_adr.size();
      repeat (100) tick();
      chk("idle_no_write", log_adr.size() - n0, 0);
      chk("idle_hold", core_hold, 1'b1);

      // directed back-to-back load, pinned with hand-computed words
      for (int k = 1; k <= 6; k++) stim.push_back(8'(k));
      for (int k = 1; k <= 6; k++) stim.push_back(8'(8'h11 * k));
      n0 = log_adr.size();
      run_load(10'h005, 2, 1'b0, 1'b0, 8'h00);
      chk("t2_adr0", log_adr[n0], 10'h005);
      chk("t2_dat0", log_dat[n0], 46'h060504030201);
      chk("t2_adr1", log_adr[n0+1], 10'h006);
      chk("t2_dat1", log_dat[n0+1], 46'h265544332211);

      // address wrap at the top of memory
      n0 = log_adr.size();
      run_load(10'h3FF, 2, 1'b0, 1'b0, 8'h00);
      chk("wrap_adr0", log_adr[n0], 10'h3FF);
      chk("wrap_adr1", log_adr[n0+1], 10'h000);

      // same data with random stalls and stray starts while busy
      for (int k = 1; k <= 6; k++) stim.push_back(8'(k));
      for (int k = 1; k <= 6; k++) stim.push_back(8'(8'h11 * k));
      n0 = log_adr.size();
      run_load(10'h005, 2, 1'b1, 1'b1, 8'h00);
      chk("stall_count", log_adr.size() - n0, 2);
      chk("stall_dat0", log_dat[n0], 46'h060504030201);
      chk("stall_dat1", log_dat[n0+1], 46'h265544332211);

      // reset three bytes into a word
      start_load(10'h100, 11'd2);
      tick();
      for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_core_hold", core_hold, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_host_ready", host_ready, 1'b0);
      chk("abort_imem_write", imem_write, 1'b0);
      chk("abort_imem_adr", imem_write_adr, '0);
      chk("abort_imem_in", imem_in, '0);
      chk("abort_done", done, 1'b0);
      chk("abort_error", error, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      run_load(AW'($urandom), 3, 1'b1, 1'b0, 8'h00);

`ifdef LOADER_CHECKSUM_EN
      for (int k = 1; k <= 6; k++) stim.push_back(8'(k));
      run_load(10'h010, 1, 1'b0, 1'b0, 8'h00);    // trailer 0x07
      for (int k = 1; k <= 6; k++) stim.push_back(8'(k));
      run_load(10'h010, 1, 1'b0, 1'b0, 8'h0F);    // trailer 0x08
      chk("ck_error_sticky", error, 1'b1);
      chk("ck_hold_sticky", core_hold, 1'b1);
`endif

      // empty load, random loads, wrap and full-depth loads
      run_load(AW'($urandom), 0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++)
         run_load(AW'($urandom), $urandom_range(1, 5), 1'b1, 1'(i), 8'h00);
      run_load(10'h3FE, 4, 1'b1, 1'b0, 8'h00);
      run_load(10'h155, 1024, 1'b0, 1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
